leaf_out_arbiter: RTL



---
 rtl/leaf_out_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter: round-robin share of one leaf-to-BFT packet channel.
// Ports: clk, reset (sync, active-high), req_vld/req_packet/req_ack,
//   dout_leaf_interface2bft, bft_ready, grant_id, stall_cnt.
// Option: LEAF_ARB_STRICT_PRIO0_EN gives requester 0 absolute priority.
module leaf_out_arbiter #(
  parameter int PACKET_BITS    = 97,
  parameter int NUM_REQ        = 4,
  parameter int PTR_BITS       = 2,
  parameter int STALL_CNT_BITS = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_vld,
  input  logic [NUM_REQ*PACKET_BITS-1:0] req_packet,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [PACKET_BITS-1:0]         dout_leaf_interface2bft,
  input  logic                           bft_ready,
  output logic [PTR_BITS-1:0]            grant_id,
  output logic [STALL_CNT_BITS-1:0]      stall_cnt
);

`ifdef LEAF_ARB_STRICT_PRIO0_EN
  localparam int RR_LO = 1;
`else
  localparam int RR_LO = 0;
`endif
  localparam logic [PTR_BITS-1:0] PTR_RST = PTR_BITS'(RR_LO);

  logic [PACKET_BITS-1:0]    out_pkt_q, out_pkt_d;
  logic [PTR_BITS-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PTR_BITS-1:0]       gid_q, gid_d;
  logic [STALL_CNT_BITS-1:0] stall_q, stall_d;
  logic [PTR_BITS-1:0]       gnt;
  logic                      hit;
  logic                      out_vld;
  logic                      load_ok;

  assign out_vld = out_pkt_q[PACKET_BITS-1];
  assign load_ok = ~out_vld | bft_ready;

  // Descending offsets so the entry nearest rr_ptr is the last writer.
  always_comb begin
    int idx;
    hit = 1'b0;
    gnt = '0;
    idx = 0;
    for (int k = NUM_REQ - 1 - RR_LO; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - (NUM_REQ - RR_LO);
      if (req_vld[idx]) begin
        hit = 1'b1;
        gnt = PTR_BITS'(idx);
      end
    end
`ifdef LEAF_ARB_STRICT_PRIO0_EN
    if (req_vld[0]) begin
      hit = 1'b1;
      gnt = '0;
    end
`endif
  end

  always_comb begin
    int nxt;
    req_ack   = '0;
    out_pkt_d = out_pkt_q;
    rr_ptr_d  = rr_ptr_q;
    gid_d     = gid_q;
    nxt       = int'(gnt) + 1;
    if (nxt >= NUM_REQ) nxt = RR_LO;
    if (load_ok) begin
      if (hit) begin
        req_ack   = NUM_REQ'(1) << gnt;
        out_pkt_d = req_packet[int'(gnt)*PACKET_BITS +: PACKET_BITS];
        out_pkt_d[PACKET_BITS-1] = 1'b1;
        gid_d     = gnt;
        // Under strict priority a grant to 0 leaves the RR ring alone.
        if (int'(gnt) >= RR_LO) rr_ptr_d = PTR_BITS'(nxt);
      end else begin
        out_pkt_d = '0;
      end
    end
    if (reset) req_ack = '0;
  end

  always_comb begin
    stall_d = stall_q;
    if (out_vld && !bft_ready && !(&stall_q))
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_pkt_q <= '0;
      rr_ptr_q  <= PTR_RST;
      gid_q     <= '0;
      stall_q   <= '0;
    end else begin
      out_pkt_q <= out_pkt_d;
      rr_ptr_q  <= rr_ptr_d;
      gid_q     <= gid_d;
      stall_q   <= stall_d;
    end
  end

  assign dout_leaf_interface2bft = out_pkt_q;
  assign grant_id                = gid_q;
  assign stall_cnt               = stall_q;

endmodule
